// File: rtl/ra_return_unit_pkg.sv
// Shared CPU package: return-address unit defaults and FSM encoding.
package ra_return_unit_pkg;

    localparam int RA_WIDTH = 3;
    localparam int RA_DEPTH = 4;

    typedef enum logic {
        RA_IDLE = 1'b0,
        RA_RESP = 1'b1
    } ra_state_e;

endpackage

// File: rtl/ra_return_unit_if.sv
// Bundle of the return unit's request/response signals.
// Handshake: Jr is a level request sampled only in IDLE; ret_valid pulses for one cycle with ret_addr.
interface ra_return_unit_if
    import ra_return_unit_pkg::*;
#(
    parameter int WIDTH = RA_WIDTH,
    parameter int DEPTH = RA_DEPTH
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic             Jal;
    logic [WIDTH-1:0] write_data_ra;
    logic             Jr;
    logic             print_regs;
    logic             ret_valid;
    logic [WIDTH-1:0] ret_addr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    ra_state_e        state;

    modport master (
        output Jal, write_data_ra, Jr, print_regs,
        input  ret_valid, ret_addr, count, overflow, underflow, state
    );

    modport slave (
        input  Jal, write_data_ra, Jr, print_regs,
        output ret_valid, ret_addr, count, overflow, underflow, state
    );
endinterface

// File: rtl/ra_stack_mem.sv
// Return-address storage: synchronous write, combinational read, no reset.
module ra_stack_mem #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ra_return_unit.sv
// Circular return-address stack with a two-state pop/response FSM.
// Pushes are independent of the FSM; a full push overwrites the oldest entry.
module ra_return_unit
    import ra_return_unit_pkg::*;
#(
    parameter int WIDTH = RA_WIDTH,
    parameter int DEPTH = RA_DEPTH
) (
    input  logic clk,
    input  logic reset,
    ra_return_unit_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ra_state_e        state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [PW-1:0]    top_ptr;
    logic [WIDTH-1:0] top_data;
    logic             pop, push, empty, full;

    // wr_ptr is the next free slot; when full it is also the oldest entry.
    assign top_ptr = wr_ptr_q - PW'(1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = bus.Jr && (state_q == RA_IDLE);
    assign push    = bus.Jal;

    ra_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.write_data_ra),
        .raddr_i (top_ptr),
        .rdata_o (top_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RA_IDLE: if (bus.Jr) state_d = RA_RESP;
            RA_RESP: state_d = RA_IDLE;
            default: state_d = RA_IDLE;
        endcase
    end

    always_comb begin
        bus.ret_valid = (state_q == RA_RESP);
        bus.state     = state_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        ret_addr_d  = ret_addr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        if (pop && push) begin
            // Swap: the pushed address replaces the top being returned.
            if (empty) begin
                ret_addr_d = bus.write_data_ra;
            end else begin
                ret_addr_d = top_data;
                mem_we     = 1'b1;
                mem_waddr  = top_ptr;
            end
        end else if (pop) begin
            if (empty) begin
                ret_addr_d  = '0;
                underflow_d = 1'b1;
            end else begin
                ret_addr_d = top_data;
                wr_ptr_d   = top_ptr;
                count_d    = count_q - CW'(1);
            end
        end else if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            ret_addr_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            ret_addr_q  <= ret_addr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.ret_addr  = ret_addr_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifndef SYNTHESIS
    logic print_regs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            print_regs_q <= 1'b0;
        end else begin
            print_regs_q <= bus.print_regs;
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.print_regs && !print_regs_q) begin
            $strobe("ra_return_unit: count=%0d top=%0d (0x%0h) overflow=%0b underflow=%0b",
                    count_q, top_data, top_data, overflow_q, underflow_q);
        end
    end
`endif
endmodule

// File: tb/tb_ra_return_unit.sv
// Directed bench for ra_return_unit with a return-address scoreboard.
module tb_ra_return_unit;
    import ra_return_unit_pkg::*;

    localparam int WIDTH = RA_WIDTH;
    localparam int DEPTH = RA_DEPTH;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [WIDTH-1:0] exp_q[$];

    ra_return_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ra_return_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // scoreboard: each ret_valid pulse consumes one expected address
    always @(negedge clk) begin
        if (!reset && bus.ret_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_ret_valid", 32'(bus.ret_valid), 32'd0);
            end else begin
                check("ret_addr", 32'(bus.ret_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.Jal = 1'b0; bus.Jr = 1'b0; bus.print_regs = 1'b0; bus.write_data_ra = '0;
        reset = 1'b1;
        #7;
        reset = 1'b0;
        tick();
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        bus.Jal = 1'b1; bus.write_data_ra = v;
        tick();
        bus.Jal = 1'b0;
    endtask

    task automatic pop(input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        bus.Jr = 1'b1;
        tick();
        bus.Jr = 1'b0;
        check("latency_pulse", 32'(bus.ret_valid), 32'd1);
        tick();
        check("pulse_end", 32'(bus.ret_valid), 32'd0);
    endtask

    task automatic pop_push(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] exp);
        exp_q.push_back(exp);
        bus.Jr = 1'b1; bus.Jal = 1'b1; bus.write_data_ra = v;
        tick();
        bus.Jr = 1'b0; bus.Jal = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;

        do_reset();
        check("rst_ret_valid", 32'(bus.ret_valid), 32'd0);
        check("rst_ret_addr", 32'(bus.ret_addr), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
        check("rst_state", 32'(bus.state), 32'(RA_IDLE));

        // basic push/pop
        push(3'd5); push(3'd3); push(3'd6);
        check("basic_count3", 32'(bus.count), 32'd3);
        pop(3'd6);
        check("basic_count2", 32'(bus.count), 32'd2);
        check("hold_ret_addr", 32'(bus.ret_addr), 32'd6);

        // overflow wraps over the oldest entry
        do_reset();
        push(3'd1); push(3'd2); push(3'd3); push(3'd4); push(3'd7);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd4);
        pop(3'd7); pop(3'd4); pop(3'd3); pop(3'd2);
        check("ovf_drained", 32'(bus.count), 32'd0);
        check("ovf_no_underflow", 32'(bus.underflow), 32'd0);

        // underflow with Jr held four cycles: two pulses
        do_reset();
        exp_q.push_back('0); exp_q.push_back('0);
        bus.Jr = 1'b1;
        repeat (4) tick();
        bus.Jr = 1'b0;
        tick();
        check("unf_pulses_seen", 32'(exp_q.size()), 32'd0);
        check("unf_flag", 32'(bus.underflow), 32'd1);
        check("unf_count", 32'(bus.count), 32'd0);
        check("unf_ret_addr", 32'(bus.ret_addr), 32'd0);

        // simultaneous pop and push
        do_reset();
        push(3'd2); push(3'd5);
        pop_push(3'd6, 3'd5);
        check("swap_count", 32'(bus.count), 32'd2);
        pop(3'd6);
        pop(3'd2);
        do_reset();
        pop_push(3'd6, 3'd6);
        check("bypass_count", 32'(bus.count), 32'd0);
        check("bypass_underflow", 32'(bus.underflow), 32'd0);

        // reset during the response cycle
        do_reset();
        pop(3'd0);
        repeat (5) push(3'($urandom_range(0, 7)));
        check("pre_rst_flags", 32'({bus.overflow, bus.underflow}), 32'd3);
        bus.Jr = 1'b1;
        tick();
        bus.Jr = 1'b0;
        check("resp_entered", 32'(bus.ret_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_drop", 32'(bus.ret_valid), 32'd0);
        check("async_count", 32'(bus.count), 32'd0);
        check("async_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        pop(3'd0);
        check("post_rst_underflow", 32'(bus.underflow), 32'd1);

        // register dump
        do_reset();
        push(3'd4);
        bus.print_regs = 1'b1;
        tick();
        bus.print_regs = 1'b0;
        tick();
        check("dump_count", 32'(bus.count), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
